// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with optional
// write-to-read bypass, an optional hardwired zero register and a sequential,
// back-pressured dump port for reading out architectural state.
//
// Ports:
//   CLK        - clock, all state updates on the rising edge
//   RST        - synchronous active-high reset (registers cleared, dump idle)
//   SA         - NUM_READ concatenated read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   Q          - NUM_READ concatenated read data, same order as SA
//   DA, D, WR  - write address, write data, write enable
//   DUMP_START - request a dump of registers DUMP_FIRST..DUMP_LAST
//   DUMP_READY - consumer ready; an entry transfers when VALID and READY are both high
//   DUMP_VALID - DUMP_ADDR/DUMP_DATA hold a valid entry
//   DUMP_ADDR  - index of the entry being presented
//   DUMP_DATA  - stored contents of register DUMP_ADDR (never bypassed)
//   DUMP_BUSY  - dump in progress
module regfile_mp #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int HAS_ZERO   = 1,
  parameter int ZERO_REG   = 31,
  parameter int BYPASS     = 1,
  parameter int DUMP_FIRST = 0,
  parameter int DUMP_LAST  = 7
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] SA,
  output logic [NUM_READ*DATA_WIDTH-1:0] Q,
  input  logic [ADDR_WIDTH-1:0]          DA,
  input  logic [DATA_WIDTH-1:0]          D,
  input  logic                           WR,
  input  logic                           DUMP_START,
  input  logic                           DUMP_READY,
  output logic                           DUMP_VALID,
  output logic [ADDR_WIDTH-1:0]          DUMP_ADDR,
  output logic [DATA_WIDTH-1:0]          DUMP_DATA,
  output logic                           DUMP_BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(DUMP_FIRST);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DUMP_LAST);
  localparam bit ZERO_EN   = (HAS_ZERO != 0);
  localparam bit BYPASS_EN = (BYPASS != 0);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } dump_state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  write_en;

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
  logic                  dump_valid_q, dump_valid_d;

  // Writes to the hardwired zero register are dropped before reaching the array.
  always_comb begin
    write_en = WR && !(ZERO_EN && (DA == ZERO_ADDR));
    mem_d = mem_q;
    if (write_en) begin
      mem_d[DA] = D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports: zero register wins over bypass, bypass wins over the array.
  always_comb begin
    Q = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (ZERO_EN && (SA[i*ADDR_WIDTH +: ADDR_WIDTH] == ZERO_ADDR)) begin
        Q[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (BYPASS_EN && WR && (SA[i*ADDR_WIDTH +: ADDR_WIDTH] == DA)) begin
        Q[i*DATA_WIDTH +: DATA_WIDTH] = D;
      end else begin
        Q[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[SA[i*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  // Dump sequencer. DUMP_START is only looked at in IDLE, so a start that
  // coincides with the last transfer (or arrives mid-dump) is ignored. The
  // address parks at DUMP_FIRST whenever the sequencer is idle.
  always_comb begin
    state_d     = state_q;
    dump_addr_d = dump_addr_q;
    case (state_q)
      S_IDLE: begin
        if (DUMP_START) begin
          state_d     = S_RUN;
          dump_addr_d = FIRST_ADDR;
        end
      end
      S_RUN: begin
        if (DUMP_READY) begin
          if (dump_addr_q == LAST_ADDR) begin
            state_d     = S_IDLE;
            dump_addr_d = FIRST_ADDR;
          end else begin
            dump_addr_d = dump_addr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        dump_addr_d = FIRST_ADDR;
      end
    endcase
    dump_valid_d = (state_d == S_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      dump_addr_q  <= FIRST_ADDR;
      dump_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dump_addr_q  <= dump_addr_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  assign DUMP_VALID = dump_valid_q;
  assign DUMP_BUSY  = dump_valid_q;
  assign DUMP_ADDR  = dump_addr_q;

  // Dump data comes straight from the array so a write while stalled shows
  // up one cycle later; it never sees the same-cycle bypass path.
  always_comb begin
    if (ZERO_EN && (dump_addr_q == ZERO_ADDR)) begin
      DUMP_DATA = '0;
    end else begin
      DUMP_DATA = mem_q[dump_addr_q];
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the datapath. It generalises the fixed 32-entry, two-read-port (SA/SB), one-write-port (DA/WR) register bank.
- Adds a configurable number of read ports, optional write-to-read bypass, and a hardwired zero register.
- Replaces the fixed r0..r7 debug taps with a sequential, back-pressured register dump port that the bench and debug logic use to read out architectural state.

Parameters:
- DATA_WIDTH, 64, bits per register.
- ADDR_WIDTH, 5, register address width; the file holds 2**ADDR_WIDTH entries.
- NUM_READ, 2, number of independent combinational read ports (≥1).
- HAS_ZERO, 1, when 1, register ZERO_REG always reads 0 and ignores writes.
- ZERO_REG, 31, index of the hardwired zero register; only used when HAS_ZERO=1.
- BYPASS, 1, when 1, a read of the register being written in the same cycle returns D (write-first).
- DUMP_FIRST, 0, first register index emitted by a dump.
- DUMP_LAST, 7, last register index emitted by a dump (DUMP_FIRST ≤ DUMP_LAST < 2**ADDR_WIDTH).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- SA  in  NUM_READ*ADDR_WIDTH  read addresses, concatenated; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- Q  out  NUM_READ*DATA_WIDTH  read data, concatenated in the same order as SA.
- DA  in  ADDR_WIDTH  write address.
- D  in  DATA_WIDTH  write data.
- WR  in  1  write enable, active-high.
- DUMP_START  in  1  request a dump of registers DUMP_FIRST..DUMP_LAST.
- DUMP_READY  in  1  consumer ready; one entry transfers when DUMP_VALID and DUMP_READY are both 1.
- DUMP_VALID  out  1  DUMP_ADDR/DUMP_DATA hold a valid entry.
- DUMP_ADDR  out  ADDR_WIDTH  index of the entry being presented.
- DUMP_DATA  out  DATA_WIDTH  contents of register DUMP_ADDR.
- DUMP_BUSY  out  1  dump in progress.

Behaviour:
- Reset (RST=1 at a rising edge):
  - All registers are cleared to 0.
  - The dump FSM goes to IDLE, so DUMP_VALID=0, DUMP_BUSY=0 and DUMP_ADDR=DUMP_FIRST.
  - RST takes priority over WR and DUMP_START in the same cycle.
  - RST asserted mid-dump aborts the dump; the next cycle is IDLE.
- Write:
  - On a rising edge with WR=1 and RST=0, D is stored to register DA.
  - When HAS_ZERO=1 and DA==ZERO_REG, the write is discarded.
  - Write latency is 1 cycle: without bypass, the new value is visible on Q in the cycle after the edge.
- Read (combinational, per port i):
  - If HAS_ZERO=1 and the address equals ZERO_REG, the port returns 0.
  - Otherwise, if BYPASS=1, WR=1 and the address equals DA, the port returns D.
  - Otherwise it returns the stored register value.
  - All ports are independent; several ports may read the same address.
- Dump FSM, states IDLE and RUN:
  - IDLE: DUMP_VALID=0 and DUMP_BUSY=0. DUMP_START=1 moves to RUN with DUMP_ADDR=DUMP_FIRST.
  - RUN: DUMP_VALID=1 and DUMP_BUSY=1. DUMP_DATA is the stored array value at DUMP_ADDR, with no bypass, and reads 0 for ZERO_REG when HAS_ZERO=1.
  - Handshake in RUN: if DUMP_READY=1, DUMP_ADDR increments; if DUMP_ADDR==DUMP_LAST, the FSM returns to IDLE instead.
  - If DUMP_READY=0, DUMP_ADDR and DUMP_VALID hold. DUMP_DATA still tracks the array, so a write to DUMP_ADDR while stalled is reflected on the next cycle.
  - DUMP_START during RUN is ignored; there is no restart.
  - DUMP_START in the cycle the FSM returns to IDLE is also ignored; a new dump starts from a later IDLE cycle.
  - A dump of N=DUMP_LAST-DUMP_FIRST+1 entries with DUMP_READY held at 1 takes exactly N RUN cycles. For example, the default 0..7 range takes 8 cycles.
  - Writes and reads proceed normally during a dump; the dump never blocks the datapath.
- Width rules:
  - DA and SA are not range-checked; every ADDR_WIDTH-bit value is a valid index.
  - DUMP_ADDR does not wrap past DUMP_LAST.

Test Plan:
- Reset, then write k to register k for k=1..7 (WR=1, one write per cycle), then read SA={7,1} → Q={7,1}. Before any write, reading SA={3,3} → {0,0}.
- Zero register: write 64'hDEAD to register 31, then read port0=31 → 0. With BYPASS=1, in the same cycle WR=1, DA=5, D=9 and port1=5 → 9 combinationally; in the next cycle, with WR=0 and port1=5 → 9.
- Dump without stall: after the first scenario, pulse DUMP_START with DUMP_READY=1 → 8 consecutive valid cycles with (DUMP_ADDR, DUMP_DATA) = (0,0),(1,1)…(7,7); then DUMP_VALID=0 and DUMP_BUSY=0.
- Dump with back-pressure: drop DUMP_READY for 3 cycles while DUMP_ADDR=2 → DUMP_ADDR holds at 2 and DUMP_VALID stays 1. During the stall, write 42 to register 2 → DUMP_DATA=42 from the next cycle. The dump then completes at address 7.
- Abort and ignored start: assert RST at DUMP_ADDR=4 → next cycle DUMP_VALID=0, DUMP_ADDR=0, and all registers read 0. A DUMP_START pulse during RUN does not alter the address sequence.
- Parameter sweep: run with NUM_READ=3, DATA_WIDTH=16, HAS_ZERO=0 and BYPASS=0, writing 16'hFFFF to register 31 → reads return 16'hFFFF from the following cycle, not in the write cycle. All 3 ports read distinct addresses correctly.
